// File: rtl/logicgate_pkg.sv
// Gate opcodes and the per-bit gate evaluator.
// The pipe applies gate_eval to every bit position to get the WIDTH-bit result.
package logicgate_pkg;

   typedef enum logic [2:0] {
      OP_BUF  = 3'd0,
      OP_NOT  = 3'd1,
      OP_AND  = 3'd2,
      OP_OR   = 3'd3,
      OP_XOR  = 3'd4,
      OP_NAND = 3'd5,
      OP_NOR  = 3'd6,
      OP_XNOR = 3'd7
   } op_t;

   function automatic logic gate_eval(input op_t op, input logic a, input logic b);
      logic r;
      case (op)
         OP_BUF:  r = a;
         OP_NOT:  r = ~a;
         OP_AND:  r = a & b;
         OP_OR:   r = a | b;
         OP_XOR:  r = a ^ b;
         OP_NAND: r = ~(a & b);
         OP_NOR:  r = ~(a | b);
         OP_XNOR: r = ~(a ^ b);
         default: r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry valid/ready buffer with a registered in_ready.
// in_ready depends only on flops, so out_ready never reaches it combinationally.
module skid_fifo2 #(
   parameter int DATA_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data
);

   logic [DATA_W-1:0] mem [2];
   logic              wr_ptr;
   logic              rd_ptr;
   logic [1:0]        count;
   logic [1:0]        count_n;
   logic              ready_q;
   logic              push;
   logic              pop;

   always_comb begin
      push    = in_valid && ready_q;
      pop     = (count != 2'd0) && out_ready;
      count_n = count;
      case ({push, pop})
         2'b10:   count_n = count + 2'd1;
         2'b01:   count_n = count - 2'd1;
         default: count_n = count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem[0]  <= '0;
         mem[1]  <= '0;
         wr_ptr  <= 1'b0;
         rd_ptr  <= 1'b0;
         count   <= 2'd0;
         ready_q <= 1'b1;
      end else begin
         if (push) begin
            mem[wr_ptr] <= in_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop)
            rd_ptr <= ~rd_ptr;
         count   <= count_n;
         ready_q <= (count_n != 2'd2);
      end
   end

   // Empty buffer presents zeros rather than a stale entry.
   assign in_ready  = ready_q;
   assign out_valid = (count != 2'd0);
   assign out_data  = out_valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/logic_gate_pipe.sv
// Registered bitwise gate unit: computes y/zero/parity on accept and queues
// them in a two-entry buffer so one result per cycle survives back-pressure.
module logic_gate_pipe
   import logicgate_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             zero,
   output logic             parity
);

   localparam int DATA_W = WIDTH + 2;

   logic [WIDTH-1:0]  y_calc;
   logic              zero_calc;
   logic              parity_calc;
   logic [DATA_W-1:0] fifo_out;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign y_calc[i] = gate_eval(op_t'(op), a[i], b[i]);
   end

   assign zero_calc   = (y_calc == '0);
   assign parity_calc = ^y_calc;

   skid_fifo2 #(
      .DATA_W (DATA_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   ({parity_calc, zero_calc, y_calc}),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (fifo_out)
   );

   assign {parity, zero, y} = fifo_out;

endmodule
